gf_plane_const_mult: RTL and testbench
======================================

# gf_plane_const_mult

Bit-plane-serial constant multiplier over GF(2^GF_WIDTH) for the CIM arithmetic datapath. NUM_LANES operands are processed in parallel, one bit-plane per transfer. Operand planes are read MSB first from the bitlines and multiplied by a runtime constant `const_in` (for example the AES MixColumns constants 0x02/0x03 or the inverse constants 0x09/0x0B/0x0D/0x0E). Product planes are then streamed back MSB first over a valid/ready interface.

## Interface
- GF_WIDTH, 8, field degree; also the number of bit-planes per operand.
- NUM_LANES, 8, number of parallel operands; one bit per lane per plane.
- GF_POLY, 8'h1B, low GF_WIDTH bits of the reduction polynomial; the x^GF_WIDTH term is implicit.

- sys_clk_in  in  1  clock; rising edge.
- sys_reset_in  in  1  reset; asynchronous, active-high.
- start_in  in  1  starts an operation; honoured only in IDLE.
- const_in  in  GF_WIDTH  multiplier constant; latched on an accepted start.
- busy_out  out  1  high whenever state != IDLE.
- plane_in  in  NUM_LANES  operand bit-plane; bit i belongs to lane i.
- plane_valid_in  in  1  plane_in valid.
- plane_ready_out  out  1  high in LOAD only.
- prod_plane_out  out  NUM_LANES  product bit-plane.
- prod_valid_out  out  1  high in DRAIN only.
- prod_ready_in  in  1  downstream accepts the product plane.
- prod_last_out  out  1  high with prod_valid_out on plane index 0.
- done_out  out  1  one-cycle pulse, registered, the cycle after the last product plane is accepted.

## Operation
- Storage:
  - op[GF_WIDTH][NUM_LANES]: operand planes.
  - acc[GF_WIDTH][NUM_LANES]: accumulator.
  - cval: latched constant.
  - idx: down-counter, width clog2(GF_WIDTH).
- States and transitions:
  - IDLE: on start_in, latch cval <= const_in, clear acc, set idx <= GF_WIDTH-1, go to LOAD.
  - LOAD: each plane_valid_in & plane_ready_out transfer stores op[idx] <= plane_in and decrements idx. The transfer at idx==0 moves to COMPUTE with idx <= GF_WIDTH-1.
  - COMPUTE: one Horner step per cycle, acc <= xtime(acc) ^ (cval[idx] ? op : 0), with idx decrementing. The step at idx==0 moves to DRAIN with idx <= GF_WIDTH-1.
  - DRAIN: prod_plane_out = acc[idx]. Each prod_valid_out & prod_ready_in transfer decrements idx. The transfer at idx==0 returns to IDLE and fires done_out on the next cycle.
- xtime on planes (per lane, all lanes at once), with m = acc[GF_WIDTH-1]:
  - new[j] = acc[j-1] ^ (m & {NUM_LANES{GF_POLY[j]}}) for j ≥ 1.
  - new[0] = m & {NUM_LANES{GF_POLY[0]}}.
- All arithmetic is XOR/AND only; there are no carries. Lanes are fully independent.
- Special constants:
  - const_in = 0 gives all-zero product planes.
  - const_in = 1 passes the operand through unchanged.
  - No shortcut is taken: cycle count is the same for every constant.
- start_in outside IDLE is ignored, and const_in is not re-sampled.
- plane_valid_in outside LOAD is ignored (ready is low).
- A start_in in the same cycle as the final DRAIN transfer is ignored; start is accepted from IDLE only.

## Timing
- Reset values:
  - State: IDLE.
  - busy_out, plane_ready_out, prod_valid_out, prod_last_out, done_out: 0.
  - prod_plane_out, acc, op, cval, idx: 0.
- Reset mid-operation aborts immediately; no partial product is emitted.
- start_in accepted at edge E: busy_out and plane_ready_out are high from cycle E+1.
- Input phase: GF_WIDTH transfers. Stalls (plane_valid_in low) hold idx and op.
- Compute phase: exactly GF_WIDTH cycles, no stalls. prod_valid_out rises GF_WIDTH cycles after the edge that accepts operand plane 0.
- Output phase: prod_plane_out and prod_last_out hold stable while prod_valid_out & !prod_ready_in.
- Back-to-back operation: with no stalls, one operation takes 1 + 2·GF_WIDTH + GF_WIDTH cycles start to done; the next start is accepted in the cycle done_out pulses.

## Test plan
- Default params, lane0 = 0x57, const 0x83, other lanes 0x00 -> lane0 product 0xC1, other lanes 0x00; done_out pulses once.
- Lanes = {0x80, 0xD4, 0x01, 0xFF, 0x57, 0x00, 0x02, 0x53}, const 0x02 -> {0x1B, 0xB3, 0x02, 0xE5, 0xAE, 0x00, 0x04, 0xA6}. Repeat with const 0x03 -> lane1 0x67, lane4 0xF9.
- Random prod_ready_in and plane_valid_in stalls, 100 random operand/constant sets including 0x0E/0x0B/0x0D/0x09 -> matches software GF model; outputs hold under stall; prod_last_out only on the 8th plane.
- Reset asserted during COMPUTE -> all outputs 0 the same cycle. A subsequent start with lane0 0x57, const 0x13 -> 0xFE, no residue from the aborted operation.
- start_in pulsed during LOAD with a different const_in -> ignored; product uses the original constant. start_in coincident with the final DRAIN transfer -> no new operation begins.
- GF_WIDTH=4, GF_POLY=4'h3, NUM_LANES=4: lanes {0x8, 0x9, 0xF, 0x1}, const 0x2 -> {0x3, 0x1, 0xD, 0x2}. const 0x0 -> all 0.

Source files
------------

// File: rtl/gf_plane_const_mult.sv
// gf_plane_const_mult: bit-plane-serial GF(2^GF_WIDTH) constant multiplier over NUM_LANES parallel lanes
// Ports:
//   sys_clk_in, sys_reset_in          clock (rising edge), asynchronous active-high reset
//   start_in, const_in, busy_out      start request (IDLE only), constant latched on start, busy flag
//   plane_in, plane_valid_in,         operand bit-planes in, MSB first, bit i = lane i
//   plane_ready_out
//   prod_plane_out, prod_valid_out,   product bit-planes out, MSB first; last flags plane 0
//   prod_ready_in, prod_last_out
//   done_out                          one-cycle pulse after the final product plane is accepted
module gf_plane_const_mult #(
    parameter int                  GF_WIDTH  = 8,
    parameter int                  NUM_LANES = 8,
    parameter logic [GF_WIDTH-1:0] GF_POLY   = 8'h1B
) (
    input  logic                 sys_clk_in,
    input  logic                 sys_reset_in,
    input  logic                 start_in,
    input  logic [GF_WIDTH-1:0]  const_in,
    output logic                 busy_out,
    input  logic [NUM_LANES-1:0] plane_in,
    input  logic                 plane_valid_in,
    output logic                 plane_ready_out,
    output logic [NUM_LANES-1:0] prod_plane_out,
    output logic                 prod_valid_out,
    input  logic                 prod_ready_in,
    output logic                 prod_last_out,
    output logic                 done_out
);
    localparam int IW = (GF_WIDTH > 1) ? $clog2(GF_WIDTH) : 1;
    localparam logic [IW-1:0] TOP = IW'(GF_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                             state_q;
    logic [GF_WIDTH-1:0][NUM_LANES-1:0] op_q, acc_q, acc_d, xt;
    logic [GF_WIDTH-1:0]                cval_q;
    logic [IW-1:0]                      idx_q, idx_d;
    logic                               done_q, last_idx;

    assign last_idx = idx_q == '0;
    assign idx_d    = last_idx ? TOP : idx_q - 1'b1;

    // Horner step on whole planes: every lane's accumulator is multiplied by x and
    // reduced at once, then the operand is added when the current constant bit is set.
    always_comb begin
        xt[0] = acc_q[GF_WIDTH-1] & {NUM_LANES{GF_POLY[0]}};
        for (int j = 1; j < GF_WIDTH; j++)
            xt[j] = acc_q[j-1] ^ (acc_q[GF_WIDTH-1] & {NUM_LANES{GF_POLY[j]}});
        acc_d = xt ^ (cval_q[idx_q] ? op_q : '0);
    end

    always_ff @(posedge sys_clk_in or posedge sys_reset_in) begin
        if (sys_reset_in) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            cval_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_in) begin
                    cval_q  <= const_in;
                    acc_q   <= '0;
                    idx_q   <= TOP;
                    state_q <= LOAD;
                end
                LOAD: if (plane_valid_in) begin
                    op_q[idx_q] <= plane_in;
                    idx_q       <= idx_d;
                    if (last_idx) state_q <= COMPUTE;
                end
                COMPUTE: begin
                    acc_q <= acc_d;
                    idx_q <= idx_d;
                    if (last_idx) state_q <= DRAIN;
                end
                DRAIN: if (prod_ready_in) begin
                    idx_q  <= idx_d;
                    done_q <= last_idx;
                    if (last_idx) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_out        = state_q != IDLE;
    assign plane_ready_out = state_q == LOAD;
    assign prod_valid_out  = state_q == DRAIN;
    assign prod_plane_out  = prod_valid_out ? acc_q[idx_q] : '0;
    assign prod_last_out   = prod_valid_out && last_idx;
    assign done_out        = done_q;
endmodule

// File: tb/tb_gf_plane_const_mult.sv
// tb_gf_plane_const_mult: scoreboard bench for the bit-plane GF constant multiplier
module tb_gf_plane_const_mult;
    localparam int W = 8, NL = 8;
    typedef logic [NL-1:0][W-1:0] lanes_t;
    typedef logic [3:0][3:0] lanes4_t;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, pvalid = 1'b0, prod_ready = 1'b0;
    logic [W-1:0]  cin = '0;
    logic [NL-1:0] pin = '0, prod;
    logic          busy, pready, prod_valid, prod_last, done;

    gf_plane_const_mult dut (
        .sys_clk_in(clk), .sys_reset_in(rst), .start_in(start), .const_in(cin),
        .busy_out(busy), .plane_in(pin), .plane_valid_in(pvalid), .plane_ready_out(pready),
        .prod_plane_out(prod), .prod_valid_out(prod_valid), .prod_ready_in(prod_ready),
        .prod_last_out(prod_last), .done_out(done)
    );

    logic       s_start = 1'b0, s_valid = 1'b0, s_pready = 1'b1;
    logic [3:0] s_c = '0, s_pin = '0, s_plane;
    logic       s_busy, s_rdy, s_pv, s_last, s_done;

    gf_plane_const_mult #(.GF_WIDTH(4), .NUM_LANES(4), .GF_POLY(4'h3)) dut4 (
        .sys_clk_in(clk), .sys_reset_in(rst), .start_in(s_start), .const_in(s_c),
        .busy_out(s_busy), .plane_in(s_pin), .plane_valid_in(s_valid), .plane_ready_out(s_rdy),
        .prod_plane_out(s_plane), .prod_valid_out(s_pv), .prod_ready_in(s_pready),
        .prod_last_out(s_last), .done_out(s_done)
    );

    int n_vec = 0, n_miss = 0, done_cnt = 0, rdy_mode = 0;
    logic [NL:0] exp_q[$];
    logic [4:0]  exp4[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // shift-and-add reference multiply in GF(2^8) mod 0x11B
    function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r ^= a;
            a = {a[W-2:0], 1'b0} ^ (a[W-1] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        prod_ready = (rdy_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    logic        hold_q = 1'b0;
    logic [NL:0] hold_v = '0;
    initial forever begin
        @(negedge clk);
        if (hold_q && prod_valid) check("hold", {prod_last, prod}, hold_v);
        hold_q = prod_valid && !prod_ready;
        hold_v = {prod_last, prod};
        if (prod_valid && prod_ready) begin
            check("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("prod", {prod_last, prod}, exp_q.pop_front());
        end
        if (done) done_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (s_pv && s_pready) begin
            check("w4_avail", exp4.size() != 0, 1);
            if (exp4.size() != 0) check("w4_prod", {s_last, s_plane}, exp4.pop_front());
        end
    end

    task automatic start_op(input logic [W-1:0] c);
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        start = 1'b1;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        cin   = W'($urandom);
        check("start_busy", {busy, pready}, 2'b11);
    endtask

    task automatic feed(input lanes_t ln, input bit stall, input bit mid);
        for (int p = W - 1; p >= 0; p--) begin
            logic [NL-1:0] pl;
            for (int l = 0; l < NL; l++) pl[l] = ln[l][p];
            while (stall && $urandom_range(0, 2) == 0) begin
                pvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            pvalid = 1'b1;
            pin    = pl;
            if (mid && p == W / 2) begin
                start = 1'b1;
                cin   = W'($urandom);
            end
            check("load_ready", pready, 1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        pvalid = 1'b0;
        pin    = '0;
    endtask

    task automatic run_op(input logic [W-1:0] c, input lanes_t ln, input lanes_t ex,
                          input bit stall, input bit mid, input bit coinc);
        int t;
        for (int p = W - 1; p >= 0; p--) begin
            logic [NL-1:0] pl;
            for (int l = 0; l < NL; l++) pl[l] = ex[l][p];
            exp_q.push_back({p == 0, pl});
        end
        done_cnt = 0;
        start_op(c);
        feed(ln, stall, mid);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!prod_valid && t < 40);
        check("latency", t, W + 1);
        t = 0;
        while (!done && t < 400) begin
            if (coinc && prod_valid && prod_last && prod_ready) begin
                start = 1'b1;
                cin   = 8'h55;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            t++;
        end
        check("done_seen", done, 1);
        check("sb_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
        check("done_count", done_cnt, 1);
        exp_q.delete();
    endtask

    task automatic run4(input logic [3:0] c, input lanes4_t ln, input lanes4_t ex);
        int t;
        for (int p = 3; p >= 0; p--) begin
            logic [3:0] pl;
            for (int l = 0; l < 4; l++) pl[l] = ex[l][p];
            exp4.push_back({p == 0, pl});
        end
        @(posedge clk);
        #1;
        s_start = 1'b1;
        s_c     = c;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int p = 3; p >= 0; p--) begin
            for (int l = 0; l < 4; l++) s_pin[l] = ln[l][p];
            s_valid = 1'b1;
            check("w4_ready", s_rdy, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        t = 0;
        while (!s_done && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("w4_done", s_done, 1);
        check("w4_drained", exp4.size(), 0);
        exp4.delete();
    endtask

    initial begin
        lanes_t            ln, ex;
        logic [3:0][W-1:0] inv = {8'h09, 8'h0D, 8'h0B, 8'h0E};
        logic [W-1:0]      c;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, pready, prod_valid, prod_last, done, prod}, 0);
        check("reset_w4", {s_busy, s_rdy, s_pv, s_last, s_done, s_plane}, 0);
        rst = 1'b0;

        ln = '0; ln[0] = 8'h57;
        ex = '0; ex[0] = 8'hC1;
        run_op(8'h83, ln, ex, 1'b1, 1'b1, 1'b0);

        ln = {8'h53, 8'h02, 8'h00, 8'h57, 8'hFF, 8'h01, 8'hD4, 8'h80};
        run_op(8'h02, ln, {8'hA6, 8'h04, 8'h00, 8'hAE, 8'hE5, 8'h02, 8'hB3, 8'h1B}, 1'b0, 1'b0, 1'b1);
        run_op(8'h03, ln, {8'hF5, 8'h06, 8'h00, 8'hF9, 8'h1A, 8'h03, 8'h67, 8'h9B}, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, ln, '0, 1'b0, 1'b0, 1'b0);
        run_op(8'h01, ln, ln, 1'b0, 1'b0, 1'b0);

        ln = {NL{8'hFF}};
        start_op(8'h83);
        feed(ln, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("pre_abort", {busy, prod_valid}, 2'b10);
        rst = 1'b1;
        #1;
        check("abort_zero", {busy, pready, prod_valid, prod_last, done, prod}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ln = '0; ln[0] = 8'h57;
        ex = '0; ex[0] = 8'hFE;
        run_op(8'h13, ln, ex, 1'b0, 1'b0, 1'b0);

        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            c = (i % 5 == 0) ? inv[(i / 5) % 4] : W'($urandom);
            for (int l = 0; l < NL; l++) begin
                ln[l] = W'($urandom);
                ex[l] = gmul(ln[l], c);
            end
            run_op(c, ln, ex, 1'b1, i % 7 == 3, 1'b0);
        end
        rdy_mode = 0;

        run4(4'h2, {4'h1, 4'hF, 4'h9, 4'h8}, {4'h2, 4'hD, 4'h1, 4'h3});
        run4(4'h0, {4'h1, 4'hF, 4'h9, 4'h8}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
